cpu_mmio_bridge: RTL and testbench
==================================

Name: cpu_mmio_bridge

Overview:
- Sits directly downstream of the single-cycle CPU's data bus (mem_addr/mem_we/mem_din/mem_dout).
- Routes accesses either to data memory or to a small MMIO register file that talks to the PDU.
- Provides buffered valid/ready handshakes for PDU→CPU input words and CPU→PDU output words, an LED register and a free-running cycle counter.

Parameters:
- MMIO_BASE, 32'h0000_7F00, base of MMIO window; bits [31:8] are compared.
- DM_AW, 8, data-memory word-address width; dm_addr = mem_addr[DM_AW+1:2].

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- mem_addr  in  32  CPU byte address.
- mem_we  in  1  CPU store strobe.
- mem_re  in  1  CPU load strobe (decoded load instruction); qualifies read side effects.
- mem_din  in  32  CPU store data.
- mem_dout  out  32  load data returned to CPU, combinational.
- dm_addr  out  DM_AW  data-memory word address.
- dm_we  out  1  data-memory write enable.
- dm_din  out  32  data-memory write data (= mem_din).
- dm_dout  in  32  data-memory read data, combinational.
- in_valid  in  1  PDU offers an input word.
- in_data  in  32  PDU input word.
- in_ready  out  1  bridge can accept an input word.
- out_valid  out  1  bridge holds an output word for PDU.
- out_data  out  32  output word.
- out_ready  in  1  PDU accepts output word.
- led  out  16  LED register.

Behaviour:
- is_io = (mem_addr[31:8] == MMIO_BASE[31:8]). dm_we = mem_we & ~is_io. dm_addr is always driven.
- Register map, offset = mem_addr[7:0]:
  - 0x00 LED, R/W, low 16 bits.
  - 0x04 IN_STAT, R, {31'b0, in_full}.
  - 0x08 IN_DATA, R, buffered input word.
  - 0x0C OUT_STAT, R, {31'b0, ~out_full}.
  - 0x10 OUT_DATA, W.
  - 0x14 CYCLE, R, 32-bit counter.
  - Unmapped offsets read 0; writes to them are ignored.
- mem_dout = is_io ? register value : dm_dout. Combinational, zero latency, so a load completes in the same cycle.
- Input buffer: one-entry holding register with in_full flag.
  - in_ready = ~in_full.
  - Transfer occurs on a clock edge where in_valid & in_ready: latch in_data and set in_full.
  - A load from IN_DATA with in_full=1 returns the word and clears in_full at the edge.
  - A load from IN_DATA with in_full=0 returns the stale word and causes no state change.
  - Simultaneous pop and push in one cycle cannot occur, because in_ready=0 whenever in_full=1.
- Output buffer: one-entry register with out_full flag.
  - out_valid = out_full.
  - A store to OUT_DATA with out_full=0 latches mem_din and sets out_full.
  - A store to OUT_DATA with out_full=1 is dropped; the held data is unchanged.
  - out_valid & out_ready at an edge clears out_full.
  - If the PDU drains the buffer and the CPU stores in the same cycle, the store is dropped, because out_full was 1 when sampled. Software must poll OUT_STAT first.
- CYCLE increments every clock and wraps from 32'hFFFF_FFFF to 0. It is read-only.
- Read side effects require mem_re=1. mem_addr that equals IN_DATA without mem_re (e.g. an ALU result) changes no state.
- mem_we and mem_re both high is illegal; the store takes priority and the read has no side effect.
- Reset (rstn low, asynchronous, any cycle) forces the following, and flags clear immediately mid-transfer:
  - led=0, in_full=0, in buffer=0, out_full=0, out_data=0, CYCLE=0.
  - Consequently in_ready=1 and out_valid=0 during reset.
- out_data stays stable while out_valid=1.

Test Plan:
- Reset: rstn=0 mid-run with out_full=1 → out_valid=0 and in_ready=1 at once; led=0, CYCLE=0 after release, then CYCLE counts 1,2,3 on successive edges.
- Memory pass-through: store 0x1234_5678 to 0x0000_0010 → dm_we=1, dm_addr=4, dm_we=0 for MMIO stores; load 0x10 returns dm_dout.
- Input handshake: in_valid=1, in_data=0xCAFE_0001 → in_ready drops next cycle, IN_STAT=1; load 0x7F08 → 0xCAFE_0001, in_ready=1 next cycle; second in_valid held while full is not accepted.
- Non-load access to 0x7F08 with mem_re=0 → in_full stays 1.
- Output backpressure: out_ready=0, store 0xA5 then 0xB6 to 0x7F10 → out_data=0xA5, second store dropped, OUT_STAT=0; out_ready=1 for one cycle → out_valid=0, OUT_STAT=1.
- LED/unmapped: store 0xFFFF_ABCD to 0x7F00 → led=16'hABCD, readback 0x0000_ABCD; load 0x7F40 → 0.

Source files
------------

// File: rtl/cpu_mmio_bridge.sv
// Address decoder between the CPU data bus and either data memory or a small
// MMIO register file (LED, buffered PDU input/output words, cycle counter).
module cpu_mmio_bridge #(
    parameter logic [31:0] MMIO_BASE = 32'h0000_7F00,
    parameter int          DM_AW     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [31:0]      mem_addr,
    input  logic             mem_we,
    input  logic             mem_re,
    input  logic [31:0]      mem_din,
    output logic [31:0]      mem_dout,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic [31:0]      dm_din,
    input  logic [31:0]      dm_dout,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready,
    output logic [15:0]      led
);

    localparam logic [7:0] OFF_LED      = 8'h00;
    localparam logic [7:0] OFF_IN_STAT  = 8'h04;
    localparam logic [7:0] OFF_IN_DATA  = 8'h08;
    localparam logic [7:0] OFF_OUT_STAT = 8'h0C;
    localparam logic [7:0] OFF_OUT_DATA = 8'h10;
    localparam logic [7:0] OFF_CYCLE    = 8'h14;

    logic        is_io;
    logic [7:0]  offset;
    logic        wr_led;
    logic        wr_out;
    logic        rd_in;
    logic        in_full;
    logic [31:0] in_buf;
    logic        out_full;
    logic [31:0] out_buf;
    logic [15:0] led_q;
    logic [31:0] cycle_q;
    logic [31:0] io_rdata;

    assign is_io  = (mem_addr[31:8] == MMIO_BASE[31:8]);
    assign offset = mem_addr[7:0];

    // A store wins over a simultaneous load, so a pop needs a pure load.
    assign wr_led = is_io & mem_we & (offset == OFF_LED);
    assign wr_out = is_io & mem_we & (offset == OFF_OUT_DATA);
    assign rd_in  = is_io & mem_re & ~mem_we & (offset == OFF_IN_DATA);

    assign dm_addr = mem_addr[DM_AW+1:2];
    assign dm_we   = mem_we & ~is_io;
    assign dm_din  = mem_din;

    assign in_ready  = ~in_full;
    assign out_valid = out_full;
    assign out_data  = out_buf;
    assign led       = led_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_full <= 1'b0;
            in_buf  <= '0;
        end else if (in_valid && !in_full) begin
            in_full <= 1'b1;
            in_buf  <= in_data;
        end else if (rd_in && in_full) begin
            in_full <= 1'b0;
        end
    end

    // Drain is checked against the pre-edge flag, so a store racing a drain is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_full <= 1'b0;
            out_buf  <= '0;
        end else if (out_full && out_ready) begin
            out_full <= 1'b0;
        end else if (wr_out && !out_full) begin
            out_full <= 1'b1;
            out_buf  <= mem_din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q   <= '0;
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (wr_led) begin
                led_q <= mem_din[15:0];
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (offset)
            OFF_LED:      io_rdata = {16'b0, led_q};
            OFF_IN_STAT:  io_rdata = {31'b0, in_full};
            OFF_IN_DATA:  io_rdata = in_buf;
            OFF_OUT_STAT: io_rdata = {31'b0, ~out_full};
            OFF_CYCLE:    io_rdata = cycle_q;
            default:      io_rdata = '0;
        endcase
    end

    assign mem_dout = is_io ? io_rdata : dm_dout;

endmodule

// File: tb/tb_cpu_mmio_bridge.sv
// Directed and randomized checks of cpu_mmio_bridge against a queue-based
// model of the register map and the two one-entry handshake buffers.
module tb_cpu_mmio_bridge;

    localparam int DM_AW = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic             mem_re;
    logic [31:0]      mem_din;
    logic [31:0]      mem_dout;
    logic [DM_AW-1:0] dm_addr;
    logic             dm_we;
    logic [31:0]      dm_din;
    logic [31:0]      dm_dout;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_data;
    logic             out_ready;
    logic [15:0]      led;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    logic [31:0] in_word;
    logic [31:0] out_word;
    logic [15:0] m_led;
    logic [31:0] m_cycle;

    always #5 clk = ~clk;

    cpu_mmio_bridge #(.MMIO_BASE(32'h0000_7F00), .DM_AW(DM_AW)) dut (
        .clk(clk), .rstn(rstn),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_din(mem_din), .mem_dout(mem_dout),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_din(dm_din), .dm_dout(dm_dout),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .led(led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_is_io();
        return mem_addr[31:8] == 24'h00_007F;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!addr_is_io()) return dm_dout;
        case (mem_addr[7:0])
            8'h00:   return {16'h0, m_led};
            8'h04:   return (in_q.size() == 1) ? 32'd1 : 32'd0;
            8'h08:   return in_word;
            8'h0C:   return (out_q.size() == 0) ? 32'd1 : 32'd0;
            8'h14:   return m_cycle;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        in_word  = 32'h0;
        out_word = 32'h0;
        m_led    = 16'h0;
        m_cycle  = 32'h0;
    endtask

    task automatic model_edge();
        logic io;
        logic store;
        logic load;
        logic in_was_full;
        logic out_was_full;
        io           = addr_is_io();
        store        = mem_we;
        load         = mem_re && !mem_we;
        in_was_full  = (in_q.size() == 1);
        out_was_full = (out_q.size() == 1);
        if (!in_was_full && in_valid) begin
            in_q.push_back(in_data);
            in_word = in_data;
        end
        if (in_was_full && io && load && mem_addr[7:0] == 8'h08) void'(in_q.pop_front());
        if (out_was_full && out_ready) void'(out_q.pop_front());
        if (!out_was_full && io && store && mem_addr[7:0] == 8'h10) begin
            out_q.push_back(mem_din);
            out_word = mem_din;
        end
        if (io && store && mem_addr[7:0] == 8'h00) m_led = mem_din[15:0];
        m_cycle = m_cycle + 32'd1;
    endtask

    task automatic check_outputs();
        chk("mem_dout", mem_dout, m_rdata());
        chk("dm_addr", {24'h0, dm_addr}, {24'h0, mem_addr[9:2]});
        chk("dm_we", {31'h0, dm_we}, {31'h0, mem_we && !addr_is_io()});
        chk("dm_din", dm_din, mem_din);
        chk("in_ready", {31'h0, in_ready}, (in_q.size() == 0) ? 32'd1 : 32'd0);
        chk("out_valid", {31'h0, out_valid}, (out_q.size() == 1) ? 32'd1 : 32'd0);
        chk("out_data", out_data, out_word);
        chk("led", {16'h0, led}, {16'h0, m_led});
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic tick();
        #2;
        check_outputs();
        @(posedge clk);
        if (rstn) model_edge();
        #1;
    endtask

    task automatic bus(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] din);
        mem_we   = we;
        mem_re   = re;
        mem_addr = addr;
        mem_din  = din;
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        mem_addr  = 32'h0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_din   = 32'h0;
        dm_dout   = 32'h0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Cycle counter after reset release
        bus(1'b0, 1'b1, 32'h7F14, 32'h0);
        chk("cycle0", mem_dout, 32'd0);
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("cycle_count", mem_dout, n);
        end

        // Memory pass-through
        dm_dout = 32'hDEAD_BEEF;
        bus(1'b1, 1'b0, 32'h0000_0010, 32'h1234_5678);
        chk("dm_we_mem", {31'h0, dm_we}, 32'd1);
        chk("dm_addr_mem", {24'h0, dm_addr}, 32'd4);
        tick();
        bus(1'b1, 1'b0, 32'h0000_7F40, 32'h5555_5555);
        chk("dm_we_io", {31'h0, dm_we}, 32'd0);
        tick();
        bus(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        chk("dm_load", mem_dout, 32'hDEAD_BEEF);
        tick();

        // Input handshake
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        in_valid = 1'b1;
        in_data  = 32'hCAFE_0001;
        #1;
        chk("in_ready_idle", {31'h0, in_ready}, 32'd1);
        tick();
        chk("in_ready_full", {31'h0, in_ready}, 32'd0);
        in_data = 32'h0000_1111;
        bus(1'b0, 1'b1, 32'h7F04, 32'h0);
        chk("in_stat", mem_dout, 32'd1);
        tick();
        bus(1'b0, 1'b0, 32'h7F08, 32'h0);
        tick();
        chk("in_nonload_keeps", {31'h0, in_ready}, 32'd0);
        bus(1'b0, 1'b1, 32'h7F08, 32'h0);
        chk("in_data_pop", mem_dout, 32'hCAFE_0001);
        tick();
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        chk("in_ready_after_pop", {31'h0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        bus(1'b0, 1'b1, 32'h7F08, 32'h0);
        chk("in_second_word", mem_dout, 32'h0000_1111);
        tick();
        chk("in_stale_read", mem_dout, 32'h0000_1111);
        tick();

        // Output backpressure
        out_ready = 1'b0;
        bus(1'b1, 1'b0, 32'h7F10, 32'h0000_00A5);
        tick();
        bus(1'b1, 1'b0, 32'h7F10, 32'h0000_00B6);
        tick();
        bus(1'b0, 1'b1, 32'h7F0C, 32'h0);
        chk("out_data_held", out_data, 32'h0000_00A5);
        chk("out_stat_full", mem_dout, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("out_valid_drained", {31'h0, out_valid}, 32'd0);
        chk("out_stat_empty", mem_dout, 32'd1);
        bus(1'b1, 1'b0, 32'h7F10, 32'h0000_00C7);
        tick();
        out_ready = 1'b1;
        bus(1'b1, 1'b0, 32'h7F10, 32'h0000_00D8);
        tick();
        out_ready = 1'b0;
        #1;
        chk("out_race_dropped", {31'h0, out_valid}, 32'd0);
        chk("out_race_data", out_data, 32'h0000_00C7);

        // LED and unmapped offsets
        bus(1'b1, 1'b0, 32'h7F00, 32'hFFFF_ABCD);
        tick();
        chk("led_value", {16'h0, led}, 32'h0000_ABCD);
        bus(1'b0, 1'b1, 32'h7F00, 32'h0);
        chk("led_readback", mem_dout, 32'h0000_ABCD);
        tick();
        bus(1'b0, 1'b1, 32'h7F40, 32'h0);
        chk("unmapped_read", mem_dout, 32'h0);
        tick();

        // Asynchronous reset with both buffers full
        in_valid = 1'b1;
        in_data  = 32'h0BAD_F00D;
        bus(1'b1, 1'b0, 32'h7F10, 32'h0000_0077);
        tick();
        in_valid = 1'b0;
        bus(1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_reset_out_valid", {31'h0, out_valid}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus(1'b0, 1'b1, 32'h7F14, 32'h0);
        chk("reset_led", {16'h0, led}, 32'h0);
        chk("reset_cycle", mem_dout, 32'd0);
        tick();
        chk("reset_cycle1", mem_dout, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] addr;
            int          op;
            case ($urandom_range(0, 3))
                0:       addr = $urandom & 32'hFFFF_FFFC;
                1, 2:    addr = 32'h7F00 | ($urandom_range(0, 6) * 4);
                default: addr = 32'h7F00 | ($urandom & 32'hFF);
            endcase
            op        = $urandom_range(0, 9);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = $urandom;
            out_ready = $urandom_range(0, 2) == 0;
            dm_dout   = $urandom;
            bus(op >= 6, (op >= 3 && op <= 5) || op == 9, addr, $urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
